// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter
// Lets two 16-bit sources share one 4-digit multiplexed 7-segment display.
// Sources are arbitrated round-robin. A granted source keeps the display for
// at least HOLD_FRAMES full scan frames. The grant can only change at a frame
// boundary, so no frame is ever shown half from one source and half from the
// other.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   req_a     source A request (level)
//   data_a    source A value, [15:12] = leftmost digit
//   req_b     source B request (level)
//   data_b    source B value
//   blank_lz  1 = blank leading zero digits (digit 0 always lit)
//   seg       segments {g,f,e,d,c,b,a}, active low, registered
//   dp        decimal point, active low; lit on digit 0 while B is shown
//   an        digit anodes, active low one-hot, an[0] = rightmost digit
//   grant     01 = A shown, 10 = B shown, 00 = idle
//   busy      grant != 00
module seg_scan_arbiter #(
    parameter int REFRESH_BITS = 16,
    parameter int HOLD_FRAMES  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [15:0] data_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHOW_A, SHOW_B} state_t;

    state_t                  state_reg, state_next;
    logic [REFRESH_BITS-1:0] presc_reg, presc_next;
    logic [1:0]              digit_reg, digit_next;
    logic [7:0]              frame_reg, frame_next;
    logic [15:0]             value_reg, value_next;
    logic                    last_b_reg, last_b_next;   // 1 = B was served last
    logic [6:0]              seg_reg, seg_next;
    logic                    dp_reg, dp_next;
    logic [3:0]              an_reg, an_next;
    logic [1:0]              grant_reg, grant_next;

    logic                    tick, frame_end, hold_done;
    logic                    cur_req, other_req;
    logic [15:0]             cur_data, other_data;
    logic [3:0]              lz;          // lz[k]: nibbles k..3 are all zero
    logic [3:0]              nibble;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    // Digit 0 is never blanked, so its flag is tied low.
    assign lz[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_lz
            assign lz[gi] = (value_reg[15:gi*4] == '0);
        end
    endgenerate

    assign tick      = (presc_reg == '1);
    assign frame_end = tick && (digit_reg == 2'd3);
    // The frame end that brings the count up to HOLD_FRAMES already counts.
    assign hold_done = (frame_reg >= 8'(HOLD_FRAMES - 1));

    assign cur_req    = (state_reg == SHOW_A) ? req_a  : req_b;
    assign other_req  = (state_reg == SHOW_A) ? req_b  : req_a;
    assign cur_data   = (state_reg == SHOW_A) ? data_a : data_b;
    assign other_data = (state_reg == SHOW_A) ? data_b : data_a;

    // Next-state logic for the arbiter and the scan counters.
    always_comb begin
        state_next  = state_reg;
        presc_next  = presc_reg;
        digit_next  = digit_reg;
        frame_next  = frame_reg;
        value_next  = value_reg;
        last_b_next = last_b_reg;
        case (state_reg)
            SHOW_A, SHOW_B: begin
                presc_next = presc_reg + REFRESH_BITS'(1);
                if (tick)
                    digit_next = digit_reg + 2'd1;
                // Follow the live value while requested, freeze it otherwise.
                if (cur_req)
                    value_next = cur_data;
                if (frame_end) begin
                    if (frame_reg < 8'(HOLD_FRAMES))
                        frame_next = frame_reg + 8'd1;
                    if (hold_done) begin
                        if (other_req) begin
                            // The prescaler and digit wrap to 0 on this edge,
                            // so the new source starts on a clean frame.
                            state_next  = (state_reg == SHOW_A) ? SHOW_B : SHOW_A;
                            value_next  = other_data;
                            frame_next  = 8'd0;
                            last_b_next = (state_reg == SHOW_A);
                        end else if (!cur_req) begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: begin
                presc_next = '0;
                digit_next = 2'd0;
                if (req_a && (!req_b || last_b_reg)) begin
                    state_next  = SHOW_A;
                    value_next  = data_a;
                    frame_next  = 8'd0;
                    last_b_next = 1'b0;
                end else if (req_b) begin
                    state_next  = SHOW_B;
                    value_next  = data_b;
                    frame_next  = 8'd0;
                    last_b_next = 1'b1;
                end
            end
        endcase
    end

    // Output drive. It is computed from the current digit, so the pins
    // lag the digit index by one register stage.
    always_comb begin
        nibble     = value_reg[{digit_reg, 2'b00} +: 4];
        seg_next   = 7'h7F;
        an_next    = 4'hF;
        dp_next    = 1'b1;
        grant_next = 2'b00;
        if (state_reg != IDLE) begin
            an_next  = ~(4'b0001 << digit_reg);
            seg_next = (blank_lz && lz[digit_reg]) ? 7'h7F : decode(nibble);
            dp_next  = !((state_reg == SHOW_B) && (digit_reg == 2'd0));
        end
        case (state_next)
            SHOW_A:  grant_next = 2'b01;
            SHOW_B:  grant_next = 2'b10;
            default: grant_next = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            presc_reg  <= '0;
            digit_reg  <= 2'd0;
            frame_reg  <= 8'd0;
            value_reg  <= 16'h0000;
            last_b_reg <= 1'b1;
            seg_reg    <= 7'h7F;
            dp_reg     <= 1'b1;
            an_reg     <= 4'hF;
            grant_reg  <= 2'b00;
        end else begin
            state_reg  <= state_next;
            presc_reg  <= presc_next;
            digit_reg  <= digit_next;
            frame_reg  <= frame_next;
            value_reg  <= value_next;
            last_b_reg <= last_b_next;
            seg_reg    <= seg_next;
            dp_reg     <= dp_next;
            an_reg     <= an_next;
            grant_reg  <= grant_next;
        end
    end

    assign seg   = seg_reg;
    assign dp    = dp_reg;
    assign an    = an_reg;
    assign grant = grant_reg;
    assign busy  = (grant_reg != 2'b00);

endmodule
